scalar_mult_ctrl: RTL
=====================

SCALAR_MULT_CTRL -- requirements
Module: scalar_mult_ctrl

Interface
REQ-001 Parameter n, default 231, coordinate/field width in bits.
REQ-002 Parameter KW, default 231, scalar width in bits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  one-cycle request; sampled only in IDLE.
REQ-006 k  input  KW  scalar; latched on accepted start.
REQ-007 px, py  input  n each  base point P; latched on accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when result is valid.
REQ-010 rx, ry  output  n each  result k*P; held until next accepted start.
REQ-011 r_inf  output  1  result is point at infinity.
REQ-012 dbl_go  output  1  one-cycle pulse starting the doubling unit.
REQ-013 dbl_x, dbl_y  output  n each  doubling operand.
REQ-014 dbl_rdy  input  1  one-cycle doubling-complete pulse.
REQ-015 dbl_x3, dbl_y3, dbl_inf  input  n, n, 1  doubling result.
REQ-016 add_go  output  1  one-cycle pulse starting the addition unit.
REQ-017 add_x1, add_y1, add_x2, add_y2  output  n each  addition operands (Q, P).
REQ-018 add_rdy  input  1  one-cycle addition-complete pulse.
REQ-019 add_x3, add_y3, add_inf  input  n, n, 1  addition result.

Function
REQ-020 Algorithm: left-to-right double-and-add over k[KW-1:0]; accumulator Q (qx, qy, q_inf) initialised to infinity on start.
REQ-021 FSM states: IDLE, SCAN, DBL_WAIT, ADD_WAIT, FIN.
REQ-022 IDLE: start=1 -> latch k, px, py; bit index i=KW-1; q_inf=1; go to SCAN next cycle.
REQ-023 SCAN, q_inf=1, k[i]=0: no unit issued, one cycle per bit.
REQ-024 SCAN, q_inf=1, k[i]=1: Q<=P directly (q_inf<=0), no unit issued, one cycle.
REQ-025 SCAN, q_inf=0: pulse dbl_go with dbl_x/dbl_y=Q, enter DBL_WAIT.
REQ-026 DBL_WAIT on dbl_rdy: Q<=dbl result (q_inf<=dbl_inf); if k[i]=1 and dbl_inf=0 then issue add step (REQ-027), else advance bit.
REQ-027 Add step: if qx==px and qy==py, pulse dbl_go with P and wait in DBL_WAIT marked as add-substitute; if qx==px and qy!=py, Q<=infinity with no unit issued; otherwise pulse add_go with (Q, P) and enter ADD_WAIT.
REQ-028 k[i]=1 with Q infinity after doubling: Q<=P, no unit issued.
REQ-029 ADD_WAIT on add_rdy: Q<=add result (q_inf<=add_inf); advance bit.
REQ-030 Advance bit: i==0 -> FIN; else i<=i-1, return to SCAN.
REQ-031 FIN: rx<=qx, ry<=qy, r_inf<=q_inf, done=1 for exactly one cycle, return to IDLE.
REQ-032 Operand outputs held stable from go pulse until matching rdy; go never reasserted while waiting.
REQ-033 dbl_rdy/add_rdy outside its matching wait state ignored; start while busy ignored.
REQ-034 At most one unit in flight at any time.
REQ-035 k=0 -> r_inf=1, rx/ry unchanged, zero go pulses.
REQ-036 Latency: KW+2 cycles from start to done plus all unit wait cycles; no hidden stalls.

Reset
REQ-037 reset=1: FSM->IDLE, busy=0, done=0, dbl_go=0, add_go=0, rx=ry=0, r_inf=1, q_inf=1, i=0.
REQ-038 Reset mid-operation abandons the computation; no done pulse; any later rdy ignored in IDLE.

Verification
REQ-039 KW=4, k=4'b0000, start -> done at cycle 6 after start, r_inf=1, zero dbl_go/add_go.
REQ-040 KW=4, k=4'b0001, P=(5,7) -> rx=5, ry=7, r_inf=0, zero go pulses.
REQ-041 KW=4, k=4'b0101, stub units fixed 3-cycle latency -> 2 dbl_go, 1 add_go, result equals model 5P.
REQ-042 Doubler stub returns (px,py) -> following add step issues dbl_go with P instead of add_go.
REQ-043 Adder stub returns add_inf=1 on last bit -> r_inf=1; qx==px with qy!=py -> infinity, no add_go.
REQ-044 reset asserted during DBL_WAIT, then dbl_rdy pulsed -> no done, busy=0, outputs at reset values.

Source files
------------

// File: rtl/scalar_mult_ctrl.sv
// Scalar multiplication sequencer: left-to-right double-and-add
// over k, driving external point-double and point-add units.
module scalar_mult_ctrl #(
  parameter int n  = 231,
  parameter int KW = 231
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] k,
  input  logic [n-1:0]  px,
  input  logic [n-1:0]  py,
  output logic          busy,
  output logic          done,
  output logic [n-1:0]  rx,
  output logic [n-1:0]  ry,
  output logic          r_inf,
  output logic          dbl_go,
  output logic [n-1:0]  dbl_x,
  output logic [n-1:0]  dbl_y,
  input  logic          dbl_rdy,
  input  logic [n-1:0]  dbl_x3,
  input  logic [n-1:0]  dbl_y3,
  input  logic          dbl_inf,
  output logic          add_go,
  output logic [n-1:0]  add_x1,
  output logic [n-1:0]  add_y1,
  output logic [n-1:0]  add_x2,
  output logic [n-1:0]  add_y2,
  input  logic          add_rdy,
  input  logic [n-1:0]  add_x3,
  input  logic [n-1:0]  add_y3,
  input  logic          add_inf
);

  localparam int IW = (KW > 1) ? $clog2(KW) : 1;

  typedef enum logic [2:0] {
    IDLE, SCAN, DBL_WAIT, ADD_WAIT, FIN
  } state_t;

  state_t state, state_n;

  logic [KW-1:0] kr;
  logic [n-1:0]  pxr, pyr;
  logic [n-1:0]  qx, qy;
  logic          q_inf;
  logic [IW-1:0] i;
  logic          sub;
  logic          bit_i;

  logic latch, ld_p, ld_dbl, ld_add, clr;
  logic iss_dbl, iss_dblp, iss_add;
  logic adv, fin;

  assign bit_i = kr[i];
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    latch    = 1'b0;
    ld_p     = 1'b0;
    ld_dbl   = 1'b0;
    ld_add   = 1'b0;
    clr      = 1'b0;
    iss_dbl  = 1'b0;
    iss_dblp = 1'b0;
    iss_add  = 1'b0;
    adv      = 1'b0;
    fin      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (q_inf) begin
          ld_p = bit_i;
          adv  = 1'b1;
        end else begin
          iss_dbl = 1'b1;
          state_n = DBL_WAIT;
        end
      end
      DBL_WAIT: begin
        if (dbl_rdy) begin
          ld_dbl = 1'b1;
          // sub: this doubling already stood in for Q+P
          if (sub || !bit_i) begin
            adv = 1'b1;
          end else if (dbl_inf) begin
            ld_p = 1'b1;
            adv  = 1'b1;
          end else if (dbl_x3 == pxr && dbl_y3 == pyr) begin
            iss_dblp = 1'b1;
          end else if (dbl_x3 == pxr) begin
            clr = 1'b1;
            adv = 1'b1;
          end else begin
            iss_add = 1'b1;
            state_n = ADD_WAIT;
          end
        end
      end
      ADD_WAIT: begin
        if (add_rdy) begin
          ld_add = 1'b1;
          adv    = 1'b1;
        end
      end
      FIN: begin
        fin     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (adv) state_n = (i == '0) ? FIN : SCAN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kr     <= '0;
      pxr    <= '0;
      pyr    <= '0;
      qx     <= '0;
      qy     <= '0;
      q_inf  <= 1'b1;
      i      <= '0;
      sub    <= 1'b0;
      done   <= 1'b0;
      rx     <= '0;
      ry     <= '0;
      r_inf  <= 1'b1;
      dbl_go <= 1'b0;
      dbl_x  <= '0;
      dbl_y  <= '0;
      add_go <= 1'b0;
      add_x1 <= '0;
      add_y1 <= '0;
      add_x2 <= '0;
      add_y2 <= '0;
    end else begin
      dbl_go <= iss_dbl | iss_dblp;
      add_go <= iss_add;
      done   <= fin;
      if (latch) begin
        kr    <= k;
        pxr   <= px;
        pyr   <= py;
        i     <= IW'(KW - 1);
        q_inf <= 1'b1;
      end
      if (ld_p) begin
        qx    <= pxr;
        qy    <= pyr;
        q_inf <= 1'b0;
      end else if (clr) begin
        q_inf <= 1'b1;
      end else if (ld_dbl) begin
        qx    <= dbl_x3;
        qy    <= dbl_y3;
        q_inf <= dbl_inf;
      end else if (ld_add) begin
        qx    <= add_x3;
        qy    <= add_y3;
        q_inf <= add_inf;
      end
      if (iss_dbl) begin
        dbl_x <= qx;
        dbl_y <= qy;
        sub   <= 1'b0;
      end
      if (iss_dblp) begin
        dbl_x <= pxr;
        dbl_y <= pyr;
        sub   <= 1'b1;
      end
      if (iss_add) begin
        add_x1 <= dbl_x3;
        add_y1 <= dbl_y3;
        add_x2 <= pxr;
        add_y2 <= pyr;
      end
      if (adv && i != '0) i <= i - 1'b1;
      if (fin) begin
        rx    <= qx;
        ry    <= qy;
        r_inf <= q_inf;
      end
    end
  end

endmodule
